// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage -- memory-access pipeline stage
//
// Sits between the execute stage and write-back. Latches the EX->MEM and
// EX->WB buses when the valid/allow handshake permits, and takes the
// synchronous data-RAM read data. That data arrives one cycle after EX
// issued the request. If write-back stalls, the stage holds the read data.
// It then formats the loaded byte/half/word and drives the MEM->WB bus.
//
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous, active-high reset
//   EX_valid         EX holds a valid instruction
//   EX_ready_go      EX output is complete this cycle
//   EXreg_2MEM       {alu_result[31:0], rkd_value[31:0], mem_we[3:0]}
//   EXreg_2WB        {rf_we, res_from_mem, rf_waddr[4:0], pc[31:0]}
//   EX_ld_op         000 ld.w, 001 ld.b, 010 ld.h, 011 ld.bu, 100 ld.hu
//   WB_allow_in      write-back can accept this cycle
//   data_sram_rdata  RAM read data, valid in the instruction's first MEM cycle
//   MEM_allow_in     this stage can accept from EX
//   MEM_ready_go     this stage's output is complete (always 1)
//   MEMreg_valid     valid toward write-back
//   MEMreg_2WB       {rf_we, rf_waddr[4:0], rf_wdata[31:0], pc[31:0]}
//   MEM_ale          (only with MEM_ALE_CHECK_EN) misaligned-load flag
//
// Optional feature macro: MEM_ALE_CHECK_EN
//   When defined, misaligned loads raise MEM_ale and suppress rf_we.
// ---------------------------------------------------------------------------
module mem_stage #(
    parameter int EX2MEM_LEN = 68,
    parameter int EX2WB_LEN  = 39,
    parameter int MEM2WB_LEN = 70
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  EX_valid,
    input  logic                  EX_ready_go,
    input  logic [EX2MEM_LEN-1:0] EXreg_2MEM,
    input  logic [EX2WB_LEN-1:0]  EXreg_2WB,
    input  logic [2:0]            EX_ld_op,
    input  logic                  WB_allow_in,
    input  logic [31:0]           data_sram_rdata,
    output logic                  MEM_allow_in,
    output logic                  MEM_ready_go,
    output logic                  MEMreg_valid,
    output logic [MEM2WB_LEN-1:0] MEMreg_2WB
`ifdef MEM_ALE_CHECK_EN
    ,
    output logic                  MEM_ale
`endif
);

    typedef enum logic {
        LIVE = 1'b0,
        HELD = 1'b1
    } hold_state_t;

    logic        MEM_valid;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_rkd_value;
    logic [3:0]  mem_mem_we;
    logic        mem_rf_we;
    logic        mem_res_from_mem;
    logic [4:0]  mem_rf_waddr;
    logic [31:0] mem_pc;
    logic [2:0]  mem_ld_op;

    hold_state_t hold_state;
    hold_state_t hold_state_next;
    logic        hold_valid;
    logic [31:0] hold_data;

    logic        ex_fire;
    logic [31:0] eff_data;
    logic [1:0]  addr;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_result;
    logic [31:0] rf_wdata;
    logic        rf_we_out;

    // Handshake: this stage never needs more than one cycle, so it can take
    // a new instruction whenever it is empty or its current one is leaving.
    assign MEM_ready_go = 1'b1;
    assign MEM_allow_in = !MEM_valid || (MEM_ready_go && WB_allow_in);
    assign MEMreg_valid = MEM_valid;
    assign ex_fire      = EX_valid && EX_ready_go;

    // Pipeline register. The valid bit follows EX on every accepting edge.
    // A bubble from EX leaves the payload fields at their previous values,
    // which avoids needless toggling.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            MEM_valid        <= 1'b0;
            mem_alu_result   <= 32'h0;
            mem_rkd_value    <= 32'h0;
            mem_mem_we       <= 4'h0;
            mem_rf_we        <= 1'b0;
            mem_res_from_mem <= 1'b0;
            mem_rf_waddr     <= 5'h0;
            mem_pc           <= 32'h0;
            mem_ld_op        <= 3'b000;
        end else if (MEM_allow_in) begin
            MEM_valid <= ex_fire;
            if (ex_fire) begin
                mem_alu_result   <= EXreg_2MEM[67:36];
                mem_rkd_value    <= EXreg_2MEM[35:4];
                mem_mem_we       <= EXreg_2MEM[3:0];
                mem_rf_we        <= EXreg_2WB[38];
                mem_res_from_mem <= EXreg_2WB[37];
                mem_rf_waddr     <= EXreg_2WB[36:32];
                mem_pc           <= EXreg_2WB[31:0];
                mem_ld_op        <= EX_ld_op;
            end
        end
    end

    // Store operands ride along in the pipeline register but are consumed
    // at the RAM interface by EX, so nothing downstream reads them.
    logic unused_carried;
    assign unused_carried = ^{mem_rkd_value, mem_mem_we};

    // Hold-buffer state register. The RAM read data is captured on the
    // same edge the stage first stalls. It must be captured then, because
    // EX may issue a new request the following cycle and overwrite the RAM
    // output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_state <= LIVE;
            hold_data  <= 32'h0;
        end else begin
            hold_state <= hold_state_next;
            if (hold_state == LIVE && hold_state_next == HELD) begin
                hold_data <= data_sram_rdata;
            end
        end
    end

    // Hold-buffer next state. The buffer enters HELD only when a real
    // instruction is stalled. It leaves on any accepting edge, and that
    // includes the edge where one instruction drains and the next is
    // accepted.
    always_comb begin
        hold_state_next = hold_state;
        case (hold_state)
            LIVE: if (MEM_valid && !WB_allow_in) hold_state_next = HELD;
            HELD: if (MEM_allow_in)              hold_state_next = LIVE;
            default:                             hold_state_next = LIVE;
        endcase
    end

    assign hold_valid = (hold_state == HELD);
    assign eff_data   = hold_valid ? hold_data : data_sram_rdata;
    assign addr       = mem_alu_result[1:0];

    // Load formatting. Misaligned addresses simply shift; with the check
    // enabled, they are flagged separately rather than altered here.
    always_comb begin
        load_byte = eff_data[7:0];
        case (addr)
            2'b00:   load_byte = eff_data[7:0];
            2'b01:   load_byte = eff_data[15:8];
            2'b10:   load_byte = eff_data[23:16];
            default: load_byte = eff_data[31:24];
        endcase
        load_half = addr[1] ? eff_data[31:16] : eff_data[15:0];

        load_result = eff_data;
        case (mem_ld_op)
            3'b001:  load_result = {{24{load_byte[7]}}, load_byte};
            3'b010:  load_result = {{16{load_half[15]}}, load_half};
            3'b011:  load_result = {24'h0, load_byte};
            3'b100:  load_result = {16'h0, load_half};
            default: load_result = eff_data;
        endcase
    end

    assign rf_wdata = mem_res_from_mem ? load_result : mem_alu_result;

`ifdef MEM_ALE_CHECK_EN
    logic is_word_load;
    logic is_half_load;
    logic misaligned;

    // Any ld_op code outside the byte/half set behaves as ld.w, so it is
    // checked for word alignment.
    assign is_word_load = !(mem_ld_op inside {3'b001, 3'b010, 3'b011, 3'b100});
    assign is_half_load = (mem_ld_op == 3'b010) || (mem_ld_op == 3'b100);
    assign misaligned   = (is_word_load && (addr != 2'b00)) ||
                          (is_half_load && addr[0]);
    assign MEM_ale      = MEM_valid && mem_res_from_mem && misaligned;
    assign rf_we_out    = mem_rf_we && !MEM_ale;
`else
    assign rf_we_out    = mem_rf_we;
`endif

    assign MEMreg_2WB = {rf_we_out, mem_rf_waddr, rf_wdata, mem_pc};

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage -- directed self-checking bench for mem_stage
//
// Drives EX inputs and RAM data on the falling edge and samples outputs
// shortly after, so every check sits away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic        EX_valid;
    logic        EX_ready_go;
    logic [67:0] EXreg_2MEM;
    logic [38:0] EXreg_2WB;
    logic [2:0]  EX_ld_op;
    logic        WB_allow_in;
    logic [31:0] data_sram_rdata;
    logic        MEM_allow_in;
    logic        MEM_ready_go;
    logic        MEMreg_valid;
    logic [69:0] MEMreg_2WB;
`ifdef MEM_ALE_CHECK_EN
    logic        MEM_ale;
`endif

    int num_checks = 0;
    int num_fails  = 0;

    mem_stage dut (
        .clk             (clk),
        .reset           (reset),
        .EX_valid        (EX_valid),
        .EX_ready_go     (EX_ready_go),
        .EXreg_2MEM      (EXreg_2MEM),
        .EXreg_2WB       (EXreg_2WB),
        .EX_ld_op        (EX_ld_op),
        .WB_allow_in     (WB_allow_in),
        .data_sram_rdata (data_sram_rdata),
        .MEM_allow_in    (MEM_allow_in),
        .MEM_ready_go    (MEM_ready_go),
        .MEMreg_valid    (MEMreg_valid),
        .MEMreg_2WB      (MEMreg_2WB)
`ifdef MEM_ALE_CHECK_EN
        ,
        .MEM_ale         (MEM_ale)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Puts one instruction (or a bubble) on the EX output buses.
    task automatic drive_ex(input logic v, input logic [31:0] alu, input logic [2:0] op,
                            input logic we, input logic rfm, input logic [4:0] waddr,
                            input logic [31:0] pc);
        EX_valid    = v;
        EX_ready_go = 1'b1;
        EXreg_2MEM  = {alu, 32'hA5A5A5A5, 4'h0};
        EXreg_2WB   = {we, rfm, waddr, pc};
        EX_ld_op    = op;
    endtask

    // Checks the values the stage drives while reset is asserted.
    task automatic test_reset;
        #2;
        num_checks++;
        if (MEMreg_valid !== 1'b0) begin
            num_fails++; $display("[TB] FAIL reset_valid: got %b expected 0", MEMreg_valid);
        end
        num_checks++;
        if (MEMreg_2WB !== 70'h0) begin
            num_fails++; $display("[TB] FAIL reset_bus: got %h expected 0", MEMreg_2WB);
        end
        num_checks++;
        if (MEM_allow_in !== 1'b1) begin
            num_fails++; $display("[TB] FAIL reset_allow_in: got %b expected 1", MEM_allow_in);
        end
        num_checks++;
        if (MEM_ready_go !== 1'b1) begin
            num_fails++; $display("[TB] FAIL ready_go: got %b expected 1", MEM_ready_go);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Checks a plain ld.w that flows straight through.
    task automatic test_load_word;
        @(negedge clk);
        WB_allow_in = 1'b1;
        drive_ex(1'b1, 32'h1000, 3'b000, 1'b1, 1'b1, 5'd3, 32'h1C000000);
        @(negedge clk);
        drive_ex(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 5'd0, 32'h0);
        data_sram_rdata = 32'hDEADBEEF;
        #1;
        num_checks++;
        if (MEMreg_valid !== 1'b1) begin
            num_fails++; $display("[TB] FAIL ldw_valid: got %b expected 1", MEMreg_valid);
        end
        num_checks++;
        if (MEMreg_2WB[63:32] !== 32'hDEADBEEF) begin
            num_fails++; $display("[TB] FAIL ldw_wdata: got %h expected deadbeef", MEMreg_2WB[63:32]);
        end
        num_checks++;
        if ({MEMreg_2WB[69], MEMreg_2WB[68:64]} !== {1'b1, 5'd3}) begin
            num_fails++; $display("[TB] FAIL ldw_we_waddr: got %b/%0d expected 1/3", MEMreg_2WB[69], MEMreg_2WB[68:64]);
        end
        num_checks++;
        if (MEMreg_2WB[31:0] !== 32'h1C000000) begin
            num_fails++; $display("[TB] FAIL ldw_pc: got %h expected 1c000000", MEMreg_2WB[31:0]);
        end
        @(negedge clk);
        #1;
        num_checks++;
        if (MEMreg_valid !== 1'b0) begin
            num_fails++; $display("[TB] FAIL ldw_bubble: got %b expected 0", MEMreg_valid);
        end
    endtask

    // Runs the byte/half extraction and extension cases from a table.
    task automatic test_load_formats;
        logic [2:0]  f_op   [0:6];
        logic [31:0] f_alu  [0:6];
        logic [31:0] f_data [0:6];
        logic [31:0] f_exp  [0:6];
        f_op[0] = 3'b001; f_alu[0] = 32'h1003; f_data[0] = 32'h80FF7F01; f_exp[0] = 32'hFFFFFF80;
        f_op[1] = 3'b011; f_alu[1] = 32'h1003; f_data[1] = 32'h80FF7F01; f_exp[1] = 32'h00000080;
        f_op[2] = 3'b100; f_alu[2] = 32'h1002; f_data[2] = 32'hABCD1234; f_exp[2] = 32'h0000ABCD;
        f_op[3] = 3'b010; f_alu[3] = 32'h1002; f_data[3] = 32'hABCD1234; f_exp[3] = 32'hFFFFABCD;
        f_op[4] = 3'b001; f_alu[4] = 32'h1001; f_data[4] = 32'h80FF7F01; f_exp[4] = 32'h0000007F;
        f_op[5] = 3'b010; f_alu[5] = 32'h1000; f_data[5] = 32'hABCD1234; f_exp[5] = 32'h00001234;
        f_op[6] = 3'b101; f_alu[6] = 32'h1000; f_data[6] = 32'h89ABCDEF; f_exp[6] = 32'h89ABCDEF;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive_ex(1'b1, f_alu[i], f_op[i], 1'b1, 1'b1, 5'd10, 32'h1C000010);
            @(negedge clk);
            drive_ex(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 5'd0, 32'h0);
            data_sram_rdata = f_data[i];
            #1;
            num_checks++;
            if (MEMreg_2WB[63:32] !== f_exp[i]) begin
                num_fails++;
                $display("[TB] FAIL format_%0d: got %h expected %h", i, MEMreg_2WB[63:32], f_exp[i]);
            end
        end
    endtask

    // Stalls a load for several cycles while the RAM output changes. Then
    // releases it together with an accept of the next load.
    task automatic test_stall;
        @(negedge clk);
        WB_allow_in = 1'b0;
        drive_ex(1'b1, 32'h2000, 3'b000, 1'b1, 1'b1, 5'd7, 32'h1C000100);
        @(negedge clk);
        drive_ex(1'b1, 32'h3000, 3'b000, 1'b1, 1'b1, 5'd9, 32'h1C000104);
        data_sram_rdata = 32'h55AA55AA;
        #1;
        num_checks++;
        if (MEM_allow_in !== 1'b0) begin
            num_fails++; $display("[TB] FAIL stall_allow_first: got %b expected 0", MEM_allow_in);
        end
        num_checks++;
        if (MEMreg_2WB[63:32] !== 32'h55AA55AA) begin
            num_fails++; $display("[TB] FAIL stall_wdata_first: got %h expected 55aa55aa", MEMreg_2WB[63:32]);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            data_sram_rdata = 32'h11111111;
            #1;
            num_checks++;
            if (MEMreg_2WB !== {1'b1, 5'd7, 32'h55AA55AA, 32'h1C000100}) begin
                num_fails++; $display("[TB] FAIL stall_bus_%0d: got %h expected held load", c, MEMreg_2WB);
            end
            num_checks++;
            if (MEM_allow_in !== 1'b0 || MEMreg_valid !== 1'b1) begin
                num_fails++; $display("[TB] FAIL stall_hs_%0d: got allow %b valid %b expected 0/1", c, MEM_allow_in, MEMreg_valid);
            end
        end
        @(negedge clk);
        WB_allow_in = 1'b1;
        #1;
        num_checks++;
        if (MEM_allow_in !== 1'b1 || MEMreg_2WB[63:32] !== 32'h55AA55AA) begin
            num_fails++; $display("[TB] FAIL stall_release: got allow %b wdata %h expected 1/55aa55aa", MEM_allow_in, MEMreg_2WB[63:32]);
        end
        @(negedge clk);
        drive_ex(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 5'd0, 32'h0);
        data_sram_rdata = 32'h12345678;
        #1;
        num_checks++;
        if (MEMreg_valid !== 1'b1 || MEMreg_2WB[68:64] !== 5'd9 || MEMreg_2WB[63:32] !== 32'h12345678) begin
            num_fails++; $display("[TB] FAIL stall_next: got valid %b waddr %0d wdata %h expected 1/9/12345678", MEMreg_valid, MEMreg_2WB[68:64], MEMreg_2WB[63:32]);
        end
        @(negedge clk);
        #1;
        num_checks++;
        if (MEMreg_valid !== 1'b0) begin
            num_fails++; $display("[TB] FAIL stall_drain: got %b expected 0", MEMreg_valid);
        end
    endtask

    // Sends two ALU results through in consecutive cycles.
    task automatic test_back_to_back;
        @(negedge clk);
        WB_allow_in = 1'b1;
        drive_ex(1'b1, 32'h00000042, 3'b000, 1'b1, 1'b0, 5'd5, 32'h1C000200);
        @(negedge clk);
        drive_ex(1'b1, 32'h00000099, 3'b000, 1'b1, 1'b0, 5'd6, 32'h1C000204);
        data_sram_rdata = 32'hFFFFFFFF;
        #1;
        num_checks++;
        if (MEMreg_valid !== 1'b1 || MEMreg_2WB[68:64] !== 5'd5 || MEMreg_2WB[63:32] !== 32'h42) begin
            num_fails++; $display("[TB] FAIL b2b_first: got valid %b waddr %0d wdata %h expected 1/5/42", MEMreg_valid, MEMreg_2WB[68:64], MEMreg_2WB[63:32]);
        end
        @(negedge clk);
        drive_ex(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 5'd0, 32'h0);
        #1;
        num_checks++;
        if (MEMreg_valid !== 1'b1 || MEMreg_2WB[68:64] !== 5'd6 || MEMreg_2WB[63:32] !== 32'h99) begin
            num_fails++; $display("[TB] FAIL b2b_second: got valid %b waddr %0d wdata %h expected 1/6/99", MEMreg_valid, MEMreg_2WB[68:64], MEMreg_2WB[63:32]);
        end
        @(negedge clk);
        #1;
        num_checks++;
        if (MEMreg_valid !== 1'b0) begin
            num_fails++; $display("[TB] FAIL b2b_end: got %b expected 0", MEMreg_valid);
        end
    endtask

    // Asserts reset mid-cycle while a load is held. Afterwards, confirms
    // that the next load sees live RAM data.
    task automatic test_reset_during_hold;
        @(negedge clk);
        WB_allow_in = 1'b0;
        drive_ex(1'b1, 32'h4000, 3'b000, 1'b1, 1'b1, 5'd4, 32'h1C000300);
        @(negedge clk);
        drive_ex(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 5'd0, 32'h0);
        data_sram_rdata = 32'hCAFEF00D;
        @(negedge clk);
        #1;
        num_checks++;
        if (dut.hold_valid !== 1'b1 || MEMreg_valid !== 1'b1) begin
            num_fails++; $display("[TB] FAIL hold_entered: got hold %b valid %b expected 1/1", dut.hold_valid, MEMreg_valid);
        end
        #1;
        reset = 1'b1;
        #1;
        num_checks++;
        if (MEMreg_valid !== 1'b0 || MEMreg_2WB !== 70'h0 || MEM_allow_in !== 1'b1) begin
            num_fails++; $display("[TB] FAIL async_reset: got valid %b bus %h allow %b expected 0/0/1", MEMreg_valid, MEMreg_2WB, MEM_allow_in);
        end
        @(negedge clk);
        reset = 1'b0;
        WB_allow_in = 1'b1;
        #1;
        num_checks++;
        if (dut.hold_valid !== 1'b0) begin
            num_fails++; $display("[TB] FAIL hold_cleared: got %b expected 0", dut.hold_valid);
        end
        drive_ex(1'b1, 32'h5000, 3'b000, 1'b1, 1'b1, 5'd2, 32'h1C000400);
        @(negedge clk);
        drive_ex(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 5'd0, 32'h0);
        data_sram_rdata = 32'h0BADF00D;
        #1;
        num_checks++;
        if (MEMreg_2WB[63:32] !== 32'h0BADF00D) begin
            num_fails++; $display("[TB] FAIL post_reset_load: got %h expected 0badf00d", MEMreg_2WB[63:32]);
        end
    endtask

`ifdef MEM_ALE_CHECK_EN
    // Checks that a misaligned ld.w is flagged and cannot write the register file.
    task automatic test_ale;
        @(negedge clk);
        WB_allow_in = 1'b1;
        drive_ex(1'b1, 32'h1001, 3'b000, 1'b1, 1'b1, 5'd8, 32'h1C000500);
        @(negedge clk);
        drive_ex(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 5'd0, 32'h0);
        data_sram_rdata = 32'h01020304;
        #1;
        num_checks++;
        if (MEM_ale !== 1'b1 || MEMreg_2WB[69] !== 1'b0) begin
            num_fails++; $display("[TB] FAIL ale_misaligned: got ale %b we %b expected 1/0", MEM_ale, MEMreg_2WB[69]);
        end
        @(negedge clk);
        #1;
        num_checks++;
        if (MEM_ale !== 1'b0) begin
            num_fails++; $display("[TB] FAIL ale_bubble: got %b expected 0", MEM_ale);
        end
    endtask
`endif

    // Runs every scenario in order, then prints the summary line.
    initial begin
        reset           = 1'b1;
        WB_allow_in     = 1'b1;
        data_sram_rdata = 32'h0;
        drive_ex(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 5'd0, 32'h0);
        test_reset;
        test_load_word;
        test_load_formats;
        test_stall;
        test_back_to_back;
        test_reset_during_hold;
`ifdef MEM_ALE_CHECK_EN
        test_ale;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
